// File: rtl/cmp_4b_alarm_fsm_if.sv
// cmp_4b_alarm_fsm_if: comparator flags and control in, alarm status out.
interface cmp_4b_alarm_fsm_if #(parameter int CNT_W = 8);
   logic             sample_valid;
   logic             a_is_equal;
   logic             a_is_greater;
   logic             a_is_smaller;
   logic             clear;
   logic [1:0]       state;
   logic             alarm;
   logic             alarm_rise;
   logic [CNT_W-1:0] event_cnt;
   logic             flag_error;
   modport master (
      output sample_valid, a_is_equal, a_is_greater, a_is_smaller, clear,
      input  state, alarm, alarm_rise, event_cnt, flag_error
   );
   modport slave (
      input  sample_valid, a_is_equal, a_is_greater, a_is_smaller, clear,
      output state, alarm, alarm_rise, event_cnt, flag_error
   );
endinterface

// File: rtl/cmp_4b_alarm_fsm.sv
// cmp_4b_alarm_fsm: debounced, hysteretic over-threshold alarm driven by 4-bit comparator flags.
module cmp_4b_alarm_fsm #(
   parameter int DEBOUNCE = 3,
   parameter int CNT_W    = 8
) (
   input logic               clk,
   input logic               rst_n,
   cmp_4b_alarm_fsm_if.slave bus
);
   typedef enum logic [1:0] {IDLE, NORMAL, ARMING, ALARM} state_t;
   localparam logic [3:0] DB = 4'(DEBOUNCE);
   state_t           state_q, state_d, cur;
   logic [3:0]       run_q, run_d, run_inc;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             alarm_q, rise_q, rise_d, err_q, err_d, one_hot, enter, g, s;
   assign g       = bus.a_is_greater;
   assign s       = bus.a_is_smaller;
   // odd parity excluding the all-high case is exactly one-hot
   assign one_hot = (bus.a_is_equal ^ g ^ s) & ~(bus.a_is_equal & g & s);
   assign run_inc = run_q + 4'd1;
   always_comb begin
      cur     = (state_q == IDLE) ? NORMAL : state_q;
      state_d = state_q;
      run_d   = run_q;
      err_d   = 1'b0;
      if (bus.sample_valid && !one_hot) begin
         err_d = 1'b1;
         run_d = 4'd0;
      end else if (bus.sample_valid) begin
         state_d = cur;
         run_d   = 4'd0;
         case (cur)
            NORMAL: if (g) begin
               state_d = (DB == 4'd1) ? ALARM : ARMING;
               run_d   = (DB == 4'd1) ? 4'd0 : 4'd1;
            end
            ARMING: begin
               state_d = !g ? NORMAL : (run_inc == DB ? ALARM : ARMING);
               run_d   = (g && run_inc != DB) ? run_inc : 4'd0;
            end
            ALARM: begin
               state_d = (s && run_inc == DB) ? NORMAL : ALARM;
               run_d   = (s && run_inc != DB) ? run_inc : 4'd0;
            end
            default: ;
         endcase
      end
      enter  = (state_d == ALARM) && (state_q != ALARM);
      rise_d = enter;
      cnt_d  = (enter && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
      if (bus.clear) begin
         state_d = IDLE;
         run_d   = 4'd0;
         err_d   = 1'b0;
         rise_d  = 1'b0;
         cnt_d   = '0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         run_q   <= 4'd0;
         cnt_q   <= '0;
         alarm_q <= 1'b0;
         rise_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         cnt_q   <= cnt_d;
         alarm_q <= state_d == ALARM;
         rise_q  <= rise_d;
         err_q   <= err_d;
      end
   end
   assign bus.state      = state_q;
   assign bus.alarm      = alarm_q;
   assign bus.alarm_rise = rise_q;
   assign bus.event_cnt  = cnt_q;
   assign bus.flag_error = err_q;
endmodule

// File: doc/cmp_4b_alarm_fsm.md
Name: cmp_4b_alarm_fsm

Overview:
- Sequential stage directly downstream of the 4-bit structural magnitude comparator.
- Consumes the comparator's a_is_equal / a_is_greater / a_is_smaller flags; in this use, a is the sample and b the threshold.
- Produces a debounced, hysteretic over-threshold alarm, a rising-edge event pulse, a saturating event counter and a flag-integrity error.
- Feeds status/interrupt logic; the three flags are consumed only when sample_valid is high.

Parameters:
- DEBOUNCE, 3: consecutive greater samples needed to enter ALARM, and consecutive smaller samples needed to leave it. Legal range 1..15.
- CNT_W, 8: width of event_cnt.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- sample_valid  input  1  flags below are valid this cycle
- a_is_equal  input  1  comparator flag, sample == threshold
- a_is_greater  input  1  comparator flag, sample > threshold
- a_is_smaller  input  1  comparator flag, sample < threshold
- clear  input  1  synchronous clear, returns the block to its reset state
- state  output  2  00 IDLE, 01 NORMAL, 10 ARMING, 11 ALARM
- alarm  output  1  high while state == ALARM
- alarm_rise  output  1  one-cycle pulse on the cycle alarm first goes high
- event_cnt  output  CNT_W  number of ALARM entries; saturates at all-ones
- flag_error  output  1  one-cycle pulse when a valid sample's flags are not one-hot

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, alarm=0, alarm_rise=0, event_cnt=0, flag_error=0, internal run counter=0. Takes effect immediately and holds while rst_n is low, including mid-debounce.
- All outputs are registered. A sample accepted at edge k is reflected in outputs during cycle k+1; latency is 1 cycle.
- Priority order: rst_n, then clear, then sample processing.
- clear=1 at an edge: same values as reset, regardless of sample_valid.
- sample_valid=0: state, run and event_cnt are held; alarm_rise=0; flag_error=0.
- Flag check on a valid sample:
  - If the flags are not exactly one-hot (all zero, or two or more high), flag_error=1 for one cycle.
  - The sample is otherwise ignored: state held, run reset to 0.
- Run counter: 4 bits. Counts consecutive qualifying samples. Reset to 0 on every state change and on every non-qualifying valid sample.
- IDLE: any one-hot valid sample moves to NORMAL, then is evaluated as a NORMAL sample in the same cycle.
- NORMAL:
  - greater: run=1 and state goes to ARMING. If DEBOUNCE==1, state goes straight to ALARM instead.
  - equal or smaller: stay in NORMAL.
- ARMING:
  - greater: run increments. When the incremented run equals DEBOUNCE, go to ALARM.
  - equal or smaller: go to NORMAL, run=0.
- ALARM (hysteresis):
  - greater or equal: stay, run=0.
  - smaller: run increments. When it reaches DEBOUNCE, go to NORMAL.
- ALARM entry actions:
  - alarm=1 from the cycle after the qualifying edge.
  - alarm_rise=1 for exactly that one cycle.
  - event_cnt increments by 1 unless it is already all-ones, in which case it stays all-ones.
- alarm is high only in ALARM; it is a registered decode of the next state.
- ALARM exit: alarm falls in the cycle after the DEBOUNCE-th smaller sample. No exit pulse.
- Valid samples need not be consecutive cycles. Gaps with sample_valid=0 do not break a run.

Test Plan:
- Reset then flags: rst_n low 2 cycles → all outputs 0, state=00. Release, then one valid equal sample → state=01 next cycle.
- Debounce entry, DEBOUNCE=3: valid greater×3 from NORMAL → state 10, 10, 11. alarm and alarm_rise rise together in the cycle after the 3rd sample; alarm_rise drops the next cycle; event_cnt=1.
- Glitch rejection: greater, greater, equal, greater → state ends in ARMING with run=1, alarm never asserts, event_cnt=0. Greater×2 with a sample_valid=0 gap between them still count as consecutive.
- Hysteresis exit: in ALARM, smaller, smaller, equal, smaller×3 → alarm stays 1 until the cycle after the 3rd consecutive smaller, then state=01 and alarm=0.
- Flag error: valid sample with greater=1 and smaller=1 in ARMING (run=2) → flag_error pulses 1 cycle, state unchanged, run=0; the next greater gives run=1 and no alarm. A valid sample with all flags 0 behaves the same.
- Saturation/clear/async reset: CNT_W=2, four ALARM entries → event_cnt=3 held. clear during ARMING → next cycle all outputs 0, IDLE. rst_n pulsed low mid-cycle in ALARM → alarm drops immediately without waiting for a clock edge.
